ghash_ctrl: RTL and testbench

//   Sequences the GF(2^128) GHASH multiplier for one AES-GCM message.
//   - Accepts AAD and ciphertext blocks over a valid/ready stream.
//   - Zero-pads partial blocks, folds each block into the running hash Y, and issues one multiply per block.
//   - Appends the final len(A)||len(C) block and returns the GHASH result.
//   - Sits between the block stream and the shared multiplier datapath.

---
 rtl/ghash_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ghash_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_ctrl.sv
// GHASH sequencer for one AES-GCM message. Folds zero-padded AAD and
// ciphertext blocks into the running hash Y through an external GF(2^128)
// multiplier, then multiplies in the len(A)||len(C) block and presents the
// final hash. The reset input rst is asynchronous and active-low.
module ghash_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 64   // two length counters fill one block
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic                  abort_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_type_i,
  input  logic [4:0]            in_bytes_i,
  input  logic                  in_last_i,
  output logic                  mul_start_o,
  output logic [DATA_WIDTH-1:0] mul_a_o,
  output logic [DATA_WIDTH-1:0] mul_h_o,
  input  logic                  mul_done_i,
  input  logic [DATA_WIDTH-1:0] mul_x_i,
  output logic [DATA_WIDTH-1:0] ghash_o,
  output logic                  ghash_valid_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_MUL_WAIT,
    S_LEN_ISSUE,
    S_LEN_WAIT,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] h_q;
  logic [DATA_WIDTH-1:0] y_q;
  logic [LEN_WIDTH-1:0]  len_a_q;
  logic [LEN_WIDTH-1:0]  len_c_q;
  logic                  seen_ct_q;
  logic                  last_pend_q;

  logic [DATA_WIDTH-1:0] blk_masked;
  logic [DATA_WIDTH-1:0] len_blk;
  logic [LEN_WIDTH-1:0]  blk_bits;
  logic                  blk_take;
  logic                  blk_illegal;
  logic                  blk_len_only;

  // A block offered in ACCEPT is consumed unless abort cancels the message.
  assign blk_take     = in_valid_i && !abort_i;
  assign blk_len_only = (in_bytes_i == 5'd0) && in_last_i;
  assign blk_illegal  = ((in_bytes_i == 5'd0) && !in_last_i) ||
                        (int'(in_bytes_i) > NBYTES) ||
                        (!in_type_i && seen_ct_q);
  assign blk_bits     = LEN_WIDTH'({in_bytes_i, 3'b000});
  assign len_blk      = {len_a_q, len_c_q};

  // Zero every byte at or beyond the valid byte count (byte 0 is the MSB).
  always_comb begin
    blk_masked = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < int'(in_bytes_i)) begin
        blk_masked[DATA_WIDTH-1-8*i -: 8] = in_data_i[DATA_WIDTH-1-8*i -: 8];
      end
    end
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the values from before the clock edge, whatever the block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every other event.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (in_valid_i && !blk_illegal) begin
          state_d = blk_len_only ? S_LEN_ISSUE : S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        if (abort_i) begin
          state_d = mul_done_i ? S_IDLE : S_DRAIN;
        end else if (mul_done_i) begin
          state_d = last_pend_q ? S_LEN_ISSUE : S_ACCEPT;
        end
      end
      S_LEN_ISSUE: begin
        state_d = abort_i ? S_IDLE : S_LEN_WAIT;
      end
      S_LEN_WAIT: begin
        if (abort_i) begin
          state_d = mul_done_i ? S_IDLE : S_DRAIN;
        end else if (mul_done_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mul_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready_o = (state_q == S_ACCEPT);
    busy_o     = (state_q != S_IDLE);
  end

  // Hash datapath: operand registers, running hash, length counters, pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q           <= '0;
      y_q           <= '0;
      len_a_q       <= '0;
      len_c_q       <= '0;
      seen_ct_q     <= 1'b0;
      last_pend_q   <= 1'b0;
      mul_start_o   <= 1'b0;
      mul_a_o       <= '0;
      mul_h_o       <= '0;
      ghash_o       <= '0;
      ghash_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      mul_start_o   <= 1'b0;
      ghash_valid_o <= 1'b0;
      err_o         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            h_q         <= h_i;
            y_q         <= '0;
            len_a_q     <= '0;
            len_c_q     <= '0;
            seen_ct_q   <= 1'b0;
            last_pend_q <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (blk_take) begin
            if (blk_illegal) begin
              err_o <= 1'b1;
            end else if (!blk_len_only) begin
              mul_a_o     <= y_q ^ blk_masked;
              mul_h_o     <= h_q;
              mul_start_o <= 1'b1;
              if (in_type_i) len_c_q <= len_c_q + blk_bits;
              else           len_a_q <= len_a_q + blk_bits;
              seen_ct_q   <= seen_ct_q | in_type_i;
              last_pend_q <= in_last_i;
            end
          end
        end
        S_MUL_WAIT: begin
          if (mul_done_i && !abort_i) y_q <= mul_x_i;
        end
        S_LEN_ISSUE: begin
          if (!abort_i) begin
            mul_a_o     <= y_q ^ len_blk;
            mul_h_o     <= h_q;
            mul_start_o <= 1'b1;
          end
        end
        S_LEN_WAIT: begin
          if (mul_done_i && !abort_i) begin
            ghash_o       <= mul_x_i;
            ghash_valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Self-checking bench for ghash_ctrl: directed messages plus randomized
// messages against a GHASH model computed straight from the GCM definition.
module tb_ghash_ctrl;

  localparam int DW      = 128;
  localparam int LW      = 64;
  localparam int MUL_LAT = 3;
  localparam logic [127:0] H0 = 128'hb83b533708bf535d0aa6e52980d53b78;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] h_i = '0;
  logic          abort_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          in_type_i = 1'b0;
  logic [4:0]    in_bytes_i = '0;
  logic          in_last_i = 1'b0;
  logic          mul_start_o;
  logic [DW-1:0] mul_a_o;
  logic [DW-1:0] mul_h_o;
  logic          mul_done_i = 1'b0;
  logic [DW-1:0] mul_x_i = '0;
  logic [DW-1:0] ghash_o;
  logic          ghash_valid_o;
  logic          busy_o;
  logic          err_o;

  ghash_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .h_i(h_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_type_i(in_type_i), .in_bytes_i(in_bytes_i), .in_last_i(in_last_i),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_h_o(mul_h_o),
    .mul_done_i(mul_done_i), .mul_x_i(mul_x_i), .ghash_o(ghash_o),
    .ghash_valid_o(ghash_valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         t;
    logic [4:0]   b;
    logic         l;
  } blk_t;

  int checks = 0;
  int errors = 0;

  logic [127:0] op_a_q[$];
  logic [127:0] op_h_q[$];
  logic [127:0] gv_q[$];
  logic [127:0] exp_ops[$];
  logic [127:0] exp_ghash;
  blk_t         msg_q[$];
  blk_t         leg_q[$];
  int           done_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // GF(2^128) product as defined for GCM (bit 0 of a block is its MSB).
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z = '0;
    logic [127:0] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // Keep the leading n bytes of a block, zero the rest.
  function automatic logic [127:0] pad_blk(input logic [127:0] d, input logic [4:0] n);
    logic [127:0] ones = '1;
    return d & ~(ones >> (8 * int'(n)));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [4:0] rand_bytes();
    return ($urandom_range(0, 1) == 0) ? 5'd16 : 5'($urandom_range(1, 16));
  endfunction

  // Behavioural multiplier with fixed latency; also records every request
  // and every ghash_valid_o pulse.
  always @(negedge clk or negedge rst) begin : mul_model
    int cnt;
    logic [127:0] pa, ph;
    if (!rst) begin
      cnt = 0;
      mul_done_i = 1'b0;
      mul_x_i = '0;
    end else begin
      mul_done_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done_i = 1'b1;
          mul_x_i = gf_mul(pa, ph);
          done_cnt++;
        end
      end
      if (mul_start_o) begin
        pa = mul_a_o;
        ph = mul_h_o;
        cnt = MUL_LAT;
        op_a_q.push_back(mul_a_o);
        op_h_q.push_back(mul_h_o);
      end
      if (ghash_valid_o) gv_q.push_back(ghash_o);
    end
  end

  // GHASH over the legal blocks of a message, straight from the definition.
  task automatic compute_expected(input logic [127:0] h);
    logic [127:0] y = '0;
    logic [127:0] m;
    logic [63:0]  la = '0;
    logic [63:0]  lc = '0;
    exp_ops.delete();
    foreach (leg_q[i]) begin
      if (leg_q[i].b != 5'd0) begin
        m = pad_blk(leg_q[i].d, leg_q[i].b);
        exp_ops.push_back(y ^ m);
        y = gf_mul(y ^ m, h);
        if (leg_q[i].t) lc = lc + 64'(leg_q[i].b) * 64'd8;
        else            la = la + 64'(leg_q[i].b) * 64'd8;
      end
    end
    exp_ops.push_back(y ^ {la, lc});
    exp_ghash = gf_mul(y ^ {la, lc}, h);
  endtask

  task automatic start_msg(input logic [127:0] h);
    op_a_q.delete();
    op_h_q.delete();
    gv_q.delete();
    h_i = h;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", 128'(busy_o), 128'd1);
  endtask

  task automatic send_block(input blk_t b, input bit illegal, input bit keep_valid);
    int waited = 0;
    in_data_i  = b.d;
    in_type_i  = b.t;
    in_bytes_i = b.b;
    in_last_i  = b.l;
    in_valid_i = 1'b1;
    while (!in_ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 128'(in_ready_o), 128'd1);
    @(negedge clk);
    if (!keep_valid) in_valid_i = 1'b0;
    check("err_pulse", 128'(err_o), 128'(illegal));
    check("ready_after_blk", 128'(in_ready_o), 128'(illegal));
  endtask

  task automatic finish_msg(input logic [127:0] h);
    int waited = 0;
    compute_expected(h);
    while (gv_q.size() == 0 && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("ghash_valid_seen", 128'(gv_q.size() != 0), 128'd1);
    if (gv_q.size() != 0) check("ghash", gv_q[0], exp_ghash);
    repeat (4) @(negedge clk);
    #1;
    check("ghash_pulses", 128'(gv_q.size()), 128'd1);
    check("ghash_hold", ghash_o, exp_ghash);
    check("idle_after", 128'(busy_o), 128'd0);
    check("mul_count", 128'(op_a_q.size()), 128'(exp_ops.size()));
    for (int i = 0; i < op_a_q.size() && i < exp_ops.size(); i++) begin
      check("mul_a", op_a_q[i], exp_ops[i]);
      check("mul_h", op_h_q[i], h);
    end
  endtask

  task automatic run_msg(input logic [127:0] h, input bit hold);
    bit seen = 1'b0;
    bit ill;
    leg_q.delete();
    start_msg(h);
    foreach (msg_q[i]) begin
      ill = ((msg_q[i].b == 5'd0) && !msg_q[i].l) || (msg_q[i].b > 5'd16) ||
            (!msg_q[i].t && seen);
      if (!ill) begin
        leg_q.push_back(msg_q[i]);
        if (msg_q[i].t) seen = 1'b1;
      end
      send_block(msg_q[i], ill, hold && !ill && (i < msg_q.size() - 1));
    end
    finish_msg(h);
  endtask

  function automatic blk_t mk(input logic [127:0] d, input logic t, input logic [4:0] b, input logic l);
    blk_t r;
    r.d = d; r.t = t; r.b = b; r.l = l;
    return r;
  endfunction

  initial begin : main
    logic [127:0] y1;
    logic [127:0] lenblk;
    int d0;
    int waited;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_ready", 128'(in_ready_o), 128'd0);
    check("rst_mul_start", 128'(mul_start_o), 128'd0);
    check("rst_mul_a", mul_a_o, 128'd0);
    check("rst_ghash", ghash_o, 128'd0);
    check("rst_ghash_valid", 128'(ghash_valid_o), 128'd0);
    check("rst_err", 128'(err_o), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready_low", 128'(in_ready_o), 128'd0);

    // 1. Empty message
    msg_q.delete();
    msg_q.push_back(mk(rnd128(), 1'b0, 5'd0, 1'b1));
    run_msg(H0, 1'b0);

    // 2. One full AAD block
    msg_q.delete();
    msg_q.push_back(mk(128'h42831ec2217774244b7221b784d0d49c, 1'b0, 5'd16, 1'b1));
    run_msg(H0, 1'b0);

    // 3. Partial ciphertext block
    msg_q.delete();
    msg_q.push_back(mk(128'hffeeddccbbaa99887766554433221100, 1'b1, 5'd5, 1'b1));
    run_msg(H0, 1'b0);
    if (op_a_q.size() >= 2) begin
      check("t3_first_op", op_a_q[0], 128'hffeeddccbb0000000000000000000000);
      y1 = gf_mul(128'hffeeddccbb0000000000000000000000, H0);
      lenblk = op_a_q[1] ^ y1;
      check("t3_len_block", lenblk, {64'd0, 64'h28});
    end

    // 4. Three AAD blocks, valid held high
    msg_q.delete();
    for (int k = 0; k < 3; k++) msg_q.push_back(mk(rnd128(), 1'b0, 5'd16, k == 2));
    run_msg(H0, 1'b1);
    check("t4_starts", 128'(op_a_q.size()), 128'd4);

    // 5. Ciphertext then AAD: the AAD block is dropped
    msg_q.delete();
    msg_q.push_back(mk(rnd128(), 1'b1, 5'd16, 1'b0));
    msg_q.push_back(mk(rnd128(), 1'b0, 5'd9, 1'b0));
    leg_q.delete();
    start_msg(H0);
    send_block(msg_q[0], 1'b0, 1'b0);
    leg_q.push_back(msg_q[0]);
    send_block(msg_q[1], 1'b1, 1'b0);
    @(negedge clk);
    check("t5_err_one_cycle", 128'(err_o), 128'd0);
    msg_q.push_back(mk(rnd128(), 1'b1, 5'd0, 1'b1));
    send_block(msg_q[2], 1'b0, 1'b0);
    leg_q.push_back(msg_q[2]);
    finish_msg(H0);

    // 6a. Abort one cycle after mul_start_o: drain, no result
    start_msg(H0);
    send_block(mk(rnd128(), 1'b0, 5'd16, 1'b0), 1'b0, 1'b0);
    check("t6_mul_start", 128'(mul_start_o), 128'd1);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t6_busy_drain", 128'(busy_o), 128'd1);
    d0 = done_cnt;
    waited = 0;
    while (done_cnt == d0 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("t6_done_seen", 128'(done_cnt != d0), 128'd1);
    @(negedge clk);
    check("t6_idle_after_drain", 128'(busy_o), 128'd0);
    repeat (3) @(negedge clk);
    check("t6_no_ghash", 128'(gv_q.size()), 128'd0);

    // 6b. Abort in ACCEPT
    start_msg(H0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t6b_idle", 128'(busy_o), 128'd0);
    check("t6b_no_mul", 128'(op_a_q.size()), 128'd0);

    // 6c. Abort together with mul_done_i: straight to IDLE
    start_msg(H0);
    send_block(mk(rnd128(), 1'b1, 5'd16, 1'b1), 1'b0, 1'b0);
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!mul_done_i && waited < 50);
    check("t6c_done_seen", 128'(mul_done_i), 128'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t6c_idle", 128'(busy_o), 128'd0);
    repeat (8) @(negedge clk);
    check("t6c_no_ghash", 128'(gv_q.size()), 128'd0);
    check("t6c_one_mul", 128'(op_a_q.size()), 128'd1);

    // 6d. Reset mid MUL_WAIT clears outputs at once
    start_msg(H0);
    send_block(mk(rnd128(), 1'b0, 5'd16, 1'b0), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("t6d_busy", 128'(busy_o), 128'd0);
    check("t6d_mul_start", 128'(mul_start_o), 128'd0);
    check("t6d_mul_a", mul_a_o, 128'd0);
    check("t6d_mul_h", mul_h_o, 128'd0);
    check("t6d_ghash", ghash_o, 128'd0);
    check("t6d_ready", 128'(in_ready_o), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Randomized messages, with illegal blocks sprinkled in
    for (int m = 0; m < 30; m++) begin
      int na;
      int nc;
      blk_t b;
      msg_q.delete();
      na = $urandom_range(0, 3);
      nc = $urandom_range(0, 3);
      for (int k = 0; k < na + nc; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          b.d = rnd128();
          b.l = 1'b0;
          b.t = (k >= na);
          case ($urandom_range(0, 2))
            0: b.b = 5'($urandom_range(17, 31));
            1: b.b = 5'd0;
            default: begin
              b.t = 1'b0;
              b.b = (k < na) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(1, 16));
            end
          endcase
          msg_q.push_back(b);
        end
        msg_q.push_back(mk(rnd128(), k >= na, rand_bytes(), 1'b0));
      end
      if (na + nc == 0 || $urandom_range(0, 3) == 0) begin
        msg_q.push_back(mk(rnd128(), nc > 0, 5'd0, 1'b1));
      end else begin
        msg_q[msg_q.size() - 1].l = 1'b1;
      end
      run_msg(rnd128(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
